// File: rtl/user_io_pkg.sv
// Shared constants for the user GPIO control block: register offsets,
// reset values and the default pad count.
package user_io_pkg;

   localparam int          NPADS_DEF     = 16;
   localparam logic [31:0] BASE_ADDR_DEF = 32'h3000_0000;

   // Byte offsets inside the 256-byte Wishbone window
   localparam logic [7:0] OFS_OUT      = 8'h00;
   localparam logic [7:0] OFS_OEB      = 8'h04;
   localparam logic [7:0] OFS_IN       = 8'h08;
   localparam logic [7:0] OFS_IRQ_EN   = 8'h0C;
   localparam logic [7:0] OFS_IRQ_STAT = 8'h10;

   // Reset values, sliced to NPADS by the user; pads come up as inputs
   localparam logic [31:0] OUT_RST    = 32'h0000_0000;
   localparam logic [31:0] OEB_RST    = 32'hFFFF_FFFF;
   localparam logic [31:0] IRQ_EN_RST = 32'h0000_0000;

endpackage

// File: rtl/user_io_sync_edge.sv
// Two-flop synchroniser plus a history flop for asynchronous pad inputs.
// sync is the metastability-safe value; edge flags a 0->1 transition of it.
module user_io_sync_edge #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] edge_rise
);

   logic [WIDTH-1:0] s1, s2, s3;

   // s1/s2 resolve metastability, s3 remembers the previous synchronised value
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync      = s2;
   assign edge_rise = s2 & ~s3;

endmodule

// File: rtl/user_io_ctrl.sv
// Wishbone slave for the user GPIO pads: output/enable registers,
// synchronised input readback, sticky rising-edge interrupts and a
// per-pad logic-analyzer override on the pad outputs.
module user_io_ctrl
   import user_io_pkg::*;
#(
   parameter int          NPADS     = NPADS_DEF,
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [NPADS-1:0] io_in,
   output logic [NPADS-1:0] io_out,
   output logic [NPADS-1:0] io_oeb,
   input  logic [NPADS-1:0] la_ovr_en,
   input  logic [NPADS-1:0] la_ovr_out,
   output logic             irq_o
);

   logic [NPADS-1:0] out_q, oeb_q, irq_en, irq_stat;
   logic [NPADS-1:0] in_sync, in_edge;
   logic [NPADS-1:0] wmask, wdata, stat_clr;
   logic [7:0]       ofs;
   logic             req, wr_req, rd_req;
   logic [31:0]      rdata;
   logic             unused_bits;

   // Only the low NPADS data bits and their byte lanes matter
   assign unused_bits = &{1'b0, wbs_dat_i, wbs_sel_i, wbs_adr_i[7:0]};

   // ~ack in the request term gives the one-cycle ack and the
   // every-other-cycle rate for back-to-back requests
   assign req    = wbs_cyc_i & wbs_stb_i &
                   (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
   assign wr_req = req &  wbs_we_i;
   assign rd_req = req & ~wbs_we_i;
   assign ofs    = wbs_adr_i[7:0];
   assign wdata  = wbs_dat_i[NPADS-1:0];

   // Per-bit write mask from the byte lane covering that bit
   for (genvar i = 0; i < NPADS; i++) begin : g_wmask
      assign wmask[i] = wbs_sel_i[i/8];
   end

   user_io_sync_edge #(.WIDTH(NPADS)) u_sync (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .din       (io_in),
      .sync      (in_sync),
      .edge_rise (in_edge)
   );

   // Read mux; unmapped offsets and bits above NPADS read as zero
   always_comb begin
      rdata = '0;
      case (ofs)
         OFS_OUT:      rdata[NPADS-1:0] = out_q;
         OFS_OEB:      rdata[NPADS-1:0] = oeb_q;
         OFS_IN:       rdata[NPADS-1:0] = in_sync;
         OFS_IRQ_EN:   rdata[NPADS-1:0] = irq_en;
         OFS_IRQ_STAT: rdata[NPADS-1:0] = irq_stat;
         default:      rdata = '0;
      endcase
   end

   // Bus handshake and read/write registers; writes commit with the ack edge
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         out_q     <= OUT_RST[NPADS-1:0];
         oeb_q     <= OEB_RST[NPADS-1:0];
         irq_en    <= IRQ_EN_RST[NPADS-1:0];
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= rd_req ? rdata : '0;
         if (wr_req) begin
            case (ofs)
               OFS_OUT:    out_q  <= (out_q  & ~wmask) | (wdata & wmask);
               OFS_OEB:    oeb_q  <= (oeb_q  & ~wmask) | (wdata & wmask);
               OFS_IRQ_EN: irq_en <= (irq_en & ~wmask) | (wdata & wmask);
               default: ;
            endcase
         end
      end
   end

   assign stat_clr = (wr_req && ofs == OFS_IRQ_STAT) ? (wdata & wmask) : '0;

   // Sticky status: a new edge in the same cycle as a W1C keeps the bit set
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) irq_stat <= '0;
      else          irq_stat <= (irq_stat & ~stat_clr) | in_edge;
   end

   // Registered level interrupt, masked by the enable register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) irq_o <= 1'b0;
      else          irq_o <= |(irq_stat & irq_en);
   end

   // LA override owns the pad and forces it to drive
   assign io_out = (la_ovr_en & la_ovr_out) | (~la_ovr_en & out_q);
   assign io_oeb = ~la_ovr_en & oeb_q;

endmodule

// File: tb/tb_user_io_ctrl.sv
// Directed bench for user_io_ctrl: register access, byte lanes, LA override,
// interrupt timing, W1C/edge collision, reset during an access, window decode.
module tb_user_io_ctrl;

   logic        wb_clk_i = 0;
   logic        wb_rst_i;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [15:0] io_in, io_out, io_oeb, la_ovr_en, la_ovr_out;
   logic        irq_o;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] B = 32'h3000_0000;

   user_io_ctrl dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oeb    (io_oeb),
      .la_ovr_en (la_ovr_en),
      .la_ovr_out(la_ovr_out),
      .irq_o     (irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Advance to 1ns past the next rising edge
   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   // One bus access, bounded to 4 edges; returns ack seen and captured data
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd, output logic got);
      @(negedge wb_clk_i);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
      got = 0; rd = '0;
      for (int i = 0; i < 4 && !got; i++) begin
         tick();
         if (wbs_ack_o) begin
            got = 1;
            rd  = wbs_dat_o;
         end
      end
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
   endtask

   task automatic wr(input string tag, input logic [7:0] ofs, input logic [31:0] dat,
                     input logic [3:0] sel);
      logic [31:0] rd; logic got;
      xfer(1'b1, B | {24'h0, ofs}, dat, sel, rd, got);
      chk({tag, "_ack"}, {31'h0, got}, 32'h1);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] ofs, input logic [31:0] exp);
      logic [31:0] rd; logic got;
      xfer(1'b0, B | {24'h0, ofs}, 32'h0, 4'hF, rd, got);
      chk({tag, "_ack"}, {31'h0, got}, 32'h1);
      chk(tag, rd, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic        got;
      wb_rst_i = 1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
      io_in = 0; la_ovr_en = 0; la_ovr_out = 0;
      repeat (3) tick();
      chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
      chk("rst_dat", wbs_dat_o, 32'h0);
      chk("rst_irq", {31'h0, irq_o}, 32'h0);
      chk("rst_io_out", {16'h0, io_out}, 32'h0);
      chk("rst_io_oeb", {16'h0, io_oeb}, 32'hFFFF);
      @(negedge wb_clk_i); wb_rst_i = 0;

      // 1: reset readback, ack lasts one cycle, dat_o returns to 0
      rd_chk("t1_oeb", 8'h04, 32'h0000_FFFF);
      chk("t1_ack_1cyc", {31'h0, wbs_ack_o}, 32'h1);
      tick();
      chk("t1_ack_drop", {31'h0, wbs_ack_o}, 32'h0);
      chk("t1_dat_idle", wbs_dat_o, 32'h0);
      rd_chk("t1_out", 8'h00, 32'h0);

      // 2: byte lanes
      wr("t2_wr", 8'h00, 32'h0000_A5A5, 4'b0001);
      rd_chk("t2_out", 8'h00, 32'h0000_00A5);
      chk("t2_io_out", {16'h0, io_out}, 32'h00A5);
      wr("t2_wr_l3", 8'h00, 32'hFFFF_0000, 4'b1100);
      rd_chk("t2_out_l3", 8'h00, 32'h0000_00A5);

      // 3: LA override on pads 0,1
      @(negedge wb_clk_i);
      la_ovr_en = 16'h0003; la_ovr_out = 16'h0002;
      #1;
      chk("t3_io_out", {16'h0, io_out}, 32'h00A6);
      chk("t3_io_oeb", {16'h0, io_oeb}, 32'hFFFC);
      rd_chk("t3_out_reg", 8'h00, 32'h0000_00A5);
      @(negedge wb_clk_i);
      la_ovr_en = 0; la_ovr_out = 0;
      wr("t3_wr_l1", 8'h00, 32'h0000_1234, 4'b0010);
      rd_chk("t3_out_l1", 8'h00, 32'h0000_12A5);

      // 4: interrupt latency and W1C
      wr("t4_en", 8'h0C, 32'h1, 4'hF);
      @(negedge wb_clk_i); io_in[0] = 1;
      tick();                                   // edge k
      tick();                                   // k+1
      chk("t4_irq_k1", {31'h0, irq_o}, 32'h0);
      tick();                                   // k+2
      chk("t4_stat_k2", {16'h0, dut.irq_stat}, 32'h1);
      chk("t4_irq_k2", {31'h0, irq_o}, 32'h0);
      tick();                                   // k+3
      chk("t4_irq_k3", {31'h0, irq_o}, 32'h1);
      rd_chk("t4_stat_rd", 8'h10, 32'h1);
      wr("t4_w1c", 8'h10, 32'h1, 4'hF);
      chk("t4_irq_at_clr", {31'h0, irq_o}, 32'h1);
      tick();
      chk("t4_irq_after", {31'h0, irq_o}, 32'h0);
      rd_chk("t4_stat_clr", 8'h10, 32'h0);

      // 5: get STAT[0]=1 again, then collide a fresh edge with a W1C
      @(negedge wb_clk_i); io_in[0] = 0;
      repeat (4) tick();
      @(negedge wb_clk_i); io_in[0] = 1;
      repeat (5) tick();
      chk("t5_irq_pre", {31'h0, irq_o}, 32'h1);
      @(negedge wb_clk_i); io_in[0] = 0;
      repeat (4) tick();
      @(negedge wb_clk_i); io_in[0] = 1;       // sampled at c-2
      @(negedge wb_clk_i);
      @(negedge wb_clk_i);                     // edge pulse is now live
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
      wbs_adr_i = B | 32'h10; wbs_dat_i = 32'h1; wbs_sel_i = 4'hF;
      tick();                                   // edge c
      chk("t5_ack", {31'h0, wbs_ack_o}, 32'h1);
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      chk("t5_stat_c", {16'h0, dut.irq_stat}, 32'h1);
      tick();
      chk("t5_irq_c1", {31'h0, irq_o}, 32'h1);
      rd_chk("t5_stat_rd", 8'h10, 32'h1);
      chk("t5_irq_hold", {31'h0, irq_o}, 32'h1);

      // W1C of zero bits, then mask via IRQ_EN
      wr("t5_w1c0", 8'h10, 32'h0, 4'hF);
      rd_chk("t5_stat_keep", 8'h10, 32'h1);
      wr("t5_en_off", 8'h0C, 32'h0, 4'hF);
      chk("t5_irq_en_edge", {31'h0, irq_o}, 32'h1);
      tick();
      chk("t5_irq_masked", {31'h0, irq_o}, 32'h0);

      // IN readback, read-only, unmapped offset, out-of-window access
      @(negedge wb_clk_i); io_in = 16'h5A3C;
      repeat (3) tick();
      rd_chk("in_rd", 8'h08, 32'h0000_5A3C);
      wr("in_wr", 8'h08, 32'h0000_FFFF, 4'hF);
      rd_chk("in_ro", 8'h08, 32'h0000_5A3C);
      wr("unmap_wr", 8'h14, 32'hFFFF_FFFF, 4'hF);
      rd_chk("unmap_rd", 8'h14, 32'h0);
      xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, rd, got);
      chk("oow_ack", {31'h0, got}, 32'h0);
      chk("oow_dat", wbs_dat_o, 32'h0);

      // 6: reset on the request edge squashes ack and the write
      wr("t6_oeb", 8'h04, 32'h0, 4'hF);
      wr("t6_en", 8'h0C, 32'hFFFF, 4'hF);
      chk("t6_oeb_pre", {16'h0, io_oeb}, 32'h0);
      @(negedge wb_clk_i);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
      wbs_adr_i = B; wbs_dat_i = 32'hFFFF; wbs_sel_i = 4'hF;
      wb_rst_i = 1;
      tick();
      chk("t6_ack_squash", {31'h0, wbs_ack_o}, 32'h0);
      @(negedge wb_clk_i);
      wb_rst_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      io_in = 0;
      chk("t6_io_out", {16'h0, io_out}, 32'h0);
      chk("t6_io_oeb", {16'h0, io_oeb}, 32'hFFFF);
      chk("t6_irq", {31'h0, irq_o}, 32'h0);
      rd_chk("t6_out", 8'h00, 32'h0);
      rd_chk("t6_oeb_rd", 8'h04, 32'h0000_FFFF);
      rd_chk("t6_en_rd", 8'h0C, 32'h0);
      rd_chk("t6_stat_rd", 8'h10, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/user_io_ctrl.md
Name: user_io_ctrl

Overview:
- Wishbone-slave configuration and control block for the user GPIO pads in the user project.
- Holds per-pad output value and output-enable registers, and synchronises pad inputs for readback.
- Latches rising-edge events into a sticky interrupt status and drives one user interrupt line.
- A logic-analyzer override path can take any pad's output away from the register file on a per-pad basis.

Parameters:
- NPADS, 16, number of pads controlled. The 16 pads are io[37:30] and io[7:0], packed {io[37:30], io[7:0]}.
- BASE_ADDR, 32'h3000_0000, Wishbone window base. Only bits [31:8] are decoded.

Ports:
- wb_clk_i  in  1  single clock for the whole block
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lane select
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- io_in  in  NPADS  pad inputs (asynchronous)
- io_out  out  NPADS  pad output values
- io_oeb  out  NPADS  pad output enables, active-low
- la_ovr_en  in  NPADS  per-pad LA override enable
- la_ovr_out  in  NPADS  LA override output value
- irq_o  out  1  interrupt, level, registered

Behaviour:
Clocking and reset:
- The block has one clock domain, wb_clk_i.
- wb_rst_i is synchronous and active-high. Every flop resets on the first clock edge at which wb_rst_i=1.

Reset values:
- wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
- OUT=0, OEB=all 1s (all pads inputs), IRQ_EN=0, IRQ_STAT=0, synchroniser stages=0.
- As a result, io_out=0 and io_oeb=all 1s whenever la_ovr_en=0.

Register map (byte offsets from BASE_ADDR; bits above NPADS read 0):
- 0x00 OUT, read/write.
- 0x04 OEB, read/write.
- 0x08 IN, read-only. Holds the synchronised input value; writes are ignored.
- 0x0C IRQ_EN, read/write. Per-pad rising-edge interrupt enable.
- 0x10 IRQ_STAT, write-1-to-clear, sticky.
- Every other offset in the window reads 0, ignores writes, and is still acked.

Wishbone handshake:
- A request is wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o.
- wbs_ack_o rises one cycle after the request and stays high for exactly one cycle. Back-to-back requests are therefore acked every other cycle.
- Write data commits on the same edge that raises ack.
- wbs_dat_o is valid while ack is high and is 0 at all other times.
- Writes honour wbs_sel_i per byte lane. Lanes 2 and 3 have no effect when NPADS=16.
- Addresses outside the window are never acked. wbs_dat_o stays 0 for them.

Input synchronisation and edge detect:
- io_in passes through a 2-flop synchroniser (s1, s2) followed by a history flop s3.
- IN reads s2.
- edge = s2 & ~s3.
- Timing for an input first sampled high at edge k:
  - s2=1 after edge k+1;
  - the IRQ_STAT bit sets at edge k+2;
  - irq_o rises at edge k+3 if that pad's IRQ_EN bit is 1.
- IRQ_STAT bits set regardless of IRQ_EN. IRQ_EN only masks irq_o.
- irq_o is registered from |(IRQ_STAT & IRQ_EN).

Simultaneous events and boundary cases:
- Same-cycle W1C and new edge on the same bit: the set wins and the bit stays 1.
- A W1C write of 0 bits leaves IRQ_STAT unchanged.
- If IRQ_EN is cleared while IRQ_STAT is set, irq_o drops on the next edge.

Pad outputs (combinational):
- io_out[i] = la_ovr_en[i] ? la_ovr_out[i] : OUT[i].
- io_oeb[i] = la_ovr_en[i] ? 0 : OEB[i].
- Register contents are not altered by the override.

Reset during an access:
- A pending ack is squashed to 0 and any in-flight write is discarded.
- The master must re-issue the access after reset deasserts.

Decomposition:
- Package user_io_pkg holds:
  - register offset constants (OFS_OUT, OFS_OEB, OFS_IN, OFS_IRQ_EN, OFS_IRQ_STAT);
  - reset constants (OEB_RST all 1s, others 0);
  - the NPADS default.
- Sub-module user_io_sync_edge, parameterised by width, contains the s1/s2/s3 flops and produces the sync and edge vectors.
- The top level contains the Wishbone decode, the registers, the IRQ logic and the override muxes.

Test Plan:
1. Release reset, then read 0x04 and 0x00 → ack high for 1 cycle, data 0x0000FFFF then 0x00000000; io_oeb=16'hFFFF.
2. Write 0x00=0x0000A5A5 with sel=4'b0001, then read 0x00 → reads 0x000000A5; io_out=16'h00A5.
3. Set la_ovr_en=16'h0003 and la_ovr_out=16'h0002 with OUT=0x00A5, OEB=0xFFFF → io_out=16'h00A6, io_oeb=16'hFFFC; a read of 0x00 still returns 0x000000A5.
4. Write IRQ_EN=0x0001, then drive io_in[0] rising (sampled at edge k) → IRQ_STAT[0]=1 at k+2, irq_o=1 at k+3. Write 0x10=0x1 → irq_o=0 one edge after the STAT clear.
5. Pulse io_in[0] so that its edge lands on the same cycle as a W1C write of 0x1 to 0x10 → IRQ_STAT[0] remains 1 and irq_o stays 1.
6. Assert wb_rst_i in the cycle after a write request (before ack) → no ack, the write is discarded, and all registers and outputs return to their reset values. An access to address 0x3000_0100 (outside the window) is never acked.
